// File: rtl/pwm_update_scheduler_pkg.sv
// Shared types and widths for the PWM shadow-register update scheduler.
package pwm_update_scheduler_pkg;

  // Compare-register width; the carrier needs one extra bit of headroom.
  localparam int unsigned PWMCOUNT_WIDTH = 15;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } pwm_onoff_e;

  typedef enum logic [1:0] {
    UPD_ZERO,
    UPD_PEAK,
    UPD_BOTH,
    UPD_IMMEDIATE
  } upd_mode_e;

  typedef enum logic [1:0] {
    S_OFF,
    S_START,
    S_RUN,
    S_STOP
  } sched_state_e;

endpackage

// File: rtl/pwm_carrier_counter.sv
// Triangular up/down carrier: 0..period..0, each extreme held for one cycle.
module pwm_carrier_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] counter,
  output logic             count_dir,
  output logic             zero,
  output logic             peak
);

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;

  // Next count: bounce at the extremes; a period lowered below the count turns it down at once.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!enable || period == '0) begin
      cnt_d = '0;
      dir_d = 1'b1;
    end else if (dir_q) begin
      if (cnt_q >= period) begin
        cnt_d = cnt_q - One;
        dir_d = 1'b0;
      end else begin
        cnt_d = cnt_q + One;
      end
    end else begin
      if (cnt_q == '0) begin
        cnt_d = One;
        dir_d = 1'b1;
      end else begin
        cnt_d = cnt_q - One;
      end
    end
  end

  // Carrier state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      dir_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign counter   = cnt_q;
  assign count_dir = dir_q;
  assign zero      = (cnt_q == '0);
  assign peak      = (cnt_q == period);

endmodule

// File: rtl/pwm_update_scheduler.sv
// Sequences PWM start/stop and decides when shadow registers load into the active masks.
module pwm_update_scheduler
  import pwm_update_scheduler_pkg::*;
#(
  parameter int unsigned CNT_W  = PWMCOUNT_WIDTH + 1,
  parameter int unsigned SKIP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  pwm_onoff_e        onoff_req,
  input  logic [CNT_W-1:0]  period,
  input  upd_mode_e         update_mode,
  input  logic [SKIP_W-1:0] skip_count,
  input  logic              commit,
  output logic [CNT_W-1:0]  counter,
  output logic              count_dir,
  output logic              mask_event,
  output pwm_onoff_e        pwm_onoff,
  output logic              update_pending,
  output sched_state_e      state
);

  sched_state_e      state_q, state_d;
  logic              pending_q, pending_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              cnt_en, zero, peak, running, eligible;

  // Counter runs in RUN/STOP but is forced back to 0 on the cycle STOP hands over to OFF.
  assign cnt_en  = (state_q == S_RUN || state_q == S_STOP) && (state_d != S_OFF);
  assign running = (state_q == S_RUN);

  pwm_carrier_counter #(
    .CNT_W (CNT_W)
  ) u_carrier (
    .clk       (clk),
    .reset     (reset),
    .enable    (cnt_en),
    .period    (period),
    .counter   (counter),
    .count_dir (count_dir),
    .zero      (zero),
    .peak      (peak)
  );

  // Run/stop sequencing; STOP drains until the carrier returns to 0 on the way down.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:   if (onoff_req == PWM_ON) state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN:   if (onoff_req == PWM_OFF) state_d = S_STOP;
      S_STOP: begin
        if (onoff_req == PWM_ON) begin
          state_d = S_RUN;
        end else if (zero && (!count_dir || period == '0)) begin
          state_d = S_OFF;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // Event eligibility and the load strobe, asserted in the same cycle as the event.
  always_comb begin
    eligible   = 1'b0;
    mask_event = 1'b0;
    case (update_mode)
      UPD_ZERO: eligible = running && zero;
      UPD_PEAK: eligible = running && peak;
      UPD_BOTH: eligible = running && (zero || peak);
      default:  eligible = 1'b0;
    endcase
    if (state_q == S_START) begin
      mask_event = 1'b1;
    end else if (running && pending_q) begin
      mask_event = (update_mode == UPD_IMMEDIATE) || (eligible && (skip_q == skip_count));
    end
  end

  // Pending flag and event prescaler; a commit racing a load wins so it is not lost.
  always_comb begin
    pending_d = pending_q;
    skip_d    = skip_q;
    if (state_d == S_OFF || state_d == S_START) begin
      pending_d = 1'b0;
      skip_d    = '0;
    end else begin
      if (commit) begin
        pending_d = 1'b1;
      end else if (mask_event) begin
        pending_d = 1'b0;
      end
      if (eligible) begin
        skip_d = (skip_q == skip_count) ? '0 : skip_q + SKIP_W'(1);
      end
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_OFF;
      pending_q <= 1'b0;
      skip_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      skip_q    <= skip_d;
    end
  end

  assign pwm_onoff      = (state_q == S_OFF) ? PWM_OFF : PWM_ON;
  assign update_pending = pending_q;
  assign state          = state_q;

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Directed bench with a cycle-level behavioural model checked on every cycle.
module tb_pwm_update_scheduler;
  import pwm_update_scheduler_pkg::*;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SKIP_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  pwm_onoff_e        onoff_req;
  logic [CNT_W-1:0]  period;
  upd_mode_e         update_mode;
  logic [SKIP_W-1:0] skip_count;
  logic              commit;
  logic [CNT_W-1:0]  counter;
  logic              count_dir;
  logic              mask_event;
  pwm_onoff_e        pwm_onoff;
  logic              update_pending;
  sched_state_e      state;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model: mode 0=off 1=start 2=run 3=stop; carrier as value plus direction of last move.
  int m_mode = 0;
  int m_cnt  = 0;
  int m_skip = 0;
  bit m_up   = 1'b1;
  bit m_pend = 1'b0;

  always #5 clk = ~clk;

  pwm_update_scheduler #(
    .CNT_W  (CNT_W),
    .SKIP_W (SKIP_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .onoff_req      (onoff_req),
    .period         (period),
    .update_mode    (update_mode),
    .skip_count     (skip_count),
    .commit         (commit),
    .counter        (counter),
    .count_dir      (count_dir),
    .mask_event     (mask_event),
    .pwm_onoff      (pwm_onoff),
    .update_pending (update_pending),
    .state          (state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  function automatic sched_state_e m_state();
    case (m_mode)
      0:       return S_OFF;
      1:       return S_START;
      2:       return S_RUN;
      default: return S_STOP;
    endcase
  endfunction

  // Expected outputs for the current cycle from model state and live inputs.
  function automatic void m_eval(output int e_cnt, output bit e_dir, output bit e_mask,
                                 output bit e_elig);
    bit is_zero, is_peak;
    e_cnt   = (m_mode >= 2) ? m_cnt : 0;
    e_dir   = (m_mode >= 2) ? m_up : 1'b1;
    is_zero = (m_mode == 2) && (e_cnt == 0);
    is_peak = (m_mode == 2) && (e_cnt == int'(period));
    case (update_mode)
      UPD_ZERO: e_elig = is_zero;
      UPD_PEAK: e_elig = is_peak;
      UPD_BOTH: e_elig = is_zero || is_peak;
      default:  e_elig = 1'b0;
    endcase
    e_mask = (m_mode == 1) ||
             ((m_mode == 2) && m_pend &&
              ((update_mode == UPD_IMMEDIATE) || (e_elig && m_skip == int'(skip_count))));
  endfunction

  // Model advance at each rising edge.
  initial begin : model_proc
    int e_cnt, nmode, p, n;
    bit e_dir, e_mask, e_elig;
    forever begin
      @(posedge clk);
      m_eval(e_cnt, e_dir, e_mask, e_elig);
      p = int'(period);
      if (reset) begin
        m_mode = 0; m_cnt = 0; m_up = 1'b1; m_pend = 1'b0; m_skip = 0;
      end else begin
        case (m_mode)
          0:       nmode = (onoff_req == PWM_ON) ? 1 : 0;
          1:       nmode = 2;
          2:       nmode = (onoff_req == PWM_OFF) ? 3 : 2;
          default: nmode = (onoff_req == PWM_ON) ? 2 :
                           ((m_cnt == 0 && (!m_up || p == 0)) ? 0 : 3);
        endcase
        if (nmode <= 1) m_skip = 0;
        else if (e_elig) m_skip = (m_skip == int'(skip_count)) ? 0 : (m_skip + 1) % 16;
        if (nmode <= 1) m_pend = 1'b0;
        else if (commit) m_pend = 1'b1;
        else if (e_mask) m_pend = 1'b0;
        if ((m_mode == 2 || m_mode == 3) && nmode != 0) begin
          if (p == 0) begin
            m_cnt = 0; m_up = 1'b1;
          end else begin
            n = m_up ? m_cnt + 1 : m_cnt - 1;
            if (n > p) begin
              n = m_cnt - 1; m_up = 1'b0;
            end else if (n < 0) begin
              n = 1; m_up = 1'b1;
            end
            m_cnt = n;
          end
        end else begin
          m_cnt = 0; m_up = 1'b1;
        end
        m_mode = nmode;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin : cmp_proc
    int e_cnt;
    bit e_dir, e_mask, e_elig;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        m_eval(e_cnt, e_dir, e_mask, e_elig);
        chk("cmp_counter", 32'(counter), 32'(e_cnt));
        chk("cmp_dir", 32'(count_dir), 32'(e_dir));
        chk("cmp_mask", 32'(mask_event), 32'(e_mask));
        chk("cmp_pending", 32'(update_pending), 32'(m_pend));
        chk("cmp_state", 32'(state), 32'(m_state()));
        chk("cmp_onoff", 32'(pwm_onoff), (m_mode == 0) ? 32'(PWM_OFF) : 32'(PWM_ON));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int seq[10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
    reset = 1'b1; onoff_req = PWM_OFF; period = 16'd4; update_mode = UPD_ZERO;
    skip_count = '0; commit = 1'b0;
    cyc(); cyc();
    cmp_en = 1'b1;
    chk("rst_state", 32'(state), 32'(S_OFF));
    chk("rst_counter", 32'(counter), 0);
    chk("rst_dir", 32'(count_dir), 1);
    chk("rst_mask", 32'(mask_event), 0);
    chk("rst_onoff", 32'(pwm_onoff), 32'(PWM_OFF));
    chk("rst_pending", 32'(update_pending), 0);

    // Commit while off is ignored.
    reset = 1'b0; commit = 1'b1;
    cyc(); commit = 1'b0;
    chk("off_commit_pending", 32'(update_pending), 0);

    // Start: one START cycle with a load strobe, then the triangle.
    onoff_req = PWM_ON;
    cyc();
    chk("start_state", 32'(state), 32'(S_START));
    chk("start_mask", 32'(mask_event), 1);
    chk("start_counter", 32'(counter), 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("tri_counter", 32'(counter), 32'(seq[i]));
      chk("tri_mask", 32'(mask_event), 0);
    end

    // Zero-mode update committed at counter 2 on the way up.
    cyc();
    chk("zero_commit_at", 32'(counter), 2);
    commit = 1'b1;
    cyc(); commit = 1'b0;
    chk("zero_pending_set", 32'(update_pending), 1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("zero_mask", 32'(mask_event), (k == 4) ? 1 : 0);
    end
    cyc();
    chk("zero_pending_clr", 32'(update_pending), 0);

    // Both-edge mode, skip one event, commit held: loads on every second event.
    update_mode = UPD_BOTH; skip_count = 4'd1; commit = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk("both_skip_mask", 32'(mask_event), (k == 7 || k == 15) ? 1 : 0);
    end
    update_mode = UPD_ZERO; skip_count = '0; commit = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("flush_mask", 32'(mask_event), (i == 6) ? 1 : 0);
    end
    cyc();
    chk("flush_pending", 32'(update_pending), 0);

    // Immediate mode: load exactly one cycle after commit.
    update_mode = UPD_IMMEDIATE;
    cyc(); cyc();
    chk("imm_commit_at", 32'(counter), 3);
    commit = 1'b1;
    cyc(); commit = 1'b0;
    chk("imm_mask", 32'(mask_event), 1);
    cyc();
    chk("imm_mask_once", 32'(mask_event), 0);
    chk("imm_pending_clr", 32'(update_pending), 0);

    // Stop request at counter 2 up: drain to zero on the way down, then off.
    update_mode = UPD_ZERO;
    repeat (5) cyc();
    chk("stop_at_counter", 32'(counter), 2);
    chk("stop_at_dir", 32'(count_dir), 1);
    onoff_req = PWM_OFF;
    cyc();
    chk("stop_state", 32'(state), 32'(S_STOP));
    chk("stop_counter3", 32'(counter), 3);
    commit = 1'b1;
    cyc(); commit = 1'b0;
    chk("stop_peak_counter", 32'(counter), 4);
    chk("stop_peak_mask", 32'(mask_event), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("stop_drain_counter", 32'(counter), 32'(3 - i));
      chk("stop_drain_mask", 32'(mask_event), 0);
    end
    cyc();
    chk("stop_off_state", 32'(state), 32'(S_OFF));
    chk("stop_off_onoff", 32'(pwm_onoff), 32'(PWM_OFF));
    chk("stop_off_pending", 32'(update_pending), 0);

    // Reset with an update pending at counter 3.
    onoff_req = PWM_ON;
    cyc(); cyc(); cyc(); cyc();
    commit = 1'b1;
    cyc(); commit = 1'b0;
    chk("rst2_counter_before", 32'(counter), 3);
    chk("rst2_pending_before", 32'(update_pending), 1);
    reset = 1'b1;
    cyc();
    chk("rst2_state", 32'(state), 32'(S_OFF));
    chk("rst2_counter", 32'(counter), 0);
    chk("rst2_mask", 32'(mask_event), 0);
    chk("rst2_pending", 32'(update_pending), 0);
    reset = 1'b0;
    cyc();
    chk("rst2_restart", 32'(state), 32'(S_START));

    // Period 0: counter pinned at 0, every cycle a zero event.
    period = '0;
    cyc();
    chk("p0_state", 32'(state), 32'(S_RUN));
    commit = 1'b1;
    cyc(); commit = 1'b0;
    chk("p0_counter", 32'(counter), 0);
    chk("p0_mask", 32'(mask_event), 1);
    cyc();
    chk("p0_pending_clr", 32'(update_pending), 0);

    // Period lowered below the count while rising forces a turn-around.
    period = 16'd4;
    cyc(); cyc(); cyc();
    chk("lower_counter_before", 32'(counter), 3);
    period = 16'd2;
    cyc();
    chk("lower_counter", 32'(counter), 2);
    chk("lower_dir", 32'(count_dir), 0);
    cyc(); cyc(); cyc(); cyc();
    chk("lower_peak", 32'(counter), 2);
    chk("lower_peak_dir", 32'(count_dir), 1);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
